// File: rtl/serial_bit_driver.sv
`timescale 1ns/1ps
// Serialises a WIDTH-bit word onto D, one bit per DIV clocks, with a one-cycle E strobe per bit.
// Latency: first bit on D the cycle after START is accepted; DONE pulses WIDTH*DIV cycles after accept.
// Backpressure: START is only honoured in IDLE; requests during SHIFT/FIN are dropped, not queued.
module serial_bit_driver #(
    parameter int WIDTH     = 8,
    parameter int DIV       = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [WIDTH-1:0] DIN,
    output logic             D,
    output logic             E,
    output logic             BUSY,
    output logic             DONE
);

    // Prescaler only ever holds 0..DIV-1, bit counter only 0..WIDTH-1.
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_FIN   = 2'd2;

    // Last prescaler value of a bit period, and the value one before it
    // (E is registered, so it is set on the edge that enters the last cycle).
    localparam logic [PW-1:0] PRE_LAST   = PW'(DIV - 1);
    localparam logic [PW-1:0] PRE_STROBE = PW'(DIV - 2);
    localparam logic [CW-1:0] LAST_BIT   = CW'(WIDTH - 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] sreg_adv;
    logic [PW-1:0]    presc;
    logic [CW-1:0]    bit_cnt;

    // Shift toward the output end, back-filling with 1s so an exhausted
    // register naturally idles D high (the downstream flop's preset value).
    always_comb begin
        sreg_adv = '1;
        if (MSB_FIRST) begin
            sreg_adv = (sreg << 1) | WIDTH'(1);
        end else begin
            sreg_adv = (sreg >> 1) | (WIDTH'(1) << (WIDTH - 1));
        end
    end

    // D is taken straight from the output end of the shift register flop.
    assign D = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];

    // Frame sequencer: accept, hold each bit DIV cycles, strobe E in the last one.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state   <= ST_IDLE;
            sreg    <= '1;
            presc   <= '0;
            bit_cnt <= '0;
            E       <= 1'b0;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (START) begin
                        sreg    <= DIN;
                        presc   <= '0;
                        bit_cnt <= '0;
                        E       <= 1'b0;
                        BUSY    <= 1'b1;
                        state   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (presc == PRE_LAST) begin
                        // Downstream flop samples the current bit on this edge.
                        E     <= 1'b0;
                        presc <= '0;
                        if (bit_cnt == LAST_BIT) begin
                            sreg    <= '1;
                            bit_cnt <= '0;
                            BUSY    <= 1'b0;
                            DONE    <= 1'b1;
                            state   <= ST_FIN;
                        end else begin
                            sreg    <= sreg_adv;
                            bit_cnt <= bit_cnt + CW'(1);
                        end
                    end else begin
                        presc <= presc + PW'(1);
                        E     <= (presc == PRE_STROBE);
                    end
                end
                ST_FIN: begin
                    // One dead cycle; START is deliberately not looked at here.
                    DONE  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    sreg  <= '1;
                    E     <= 1'b0;
                    BUSY  <= 1'b0;
                    DONE  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_bit_driver.sv
`timescale 1ns/1ps
module tb_serial_bit_driver;

    logic       CLK;
    logic       RST;
    logic [2:0] start;
    logic [7:0] din0;
    logic [7:0] din1;
    logic [3:0] din2;
    logic [2:0] d_o;
    logic [2:0] e_o;
    logic [2:0] busy_o;
    logic [2:0] done_o;

    int vectors;
    int miscompares;

    // Instance 0: WIDTH=8 DIV=4 MSB first; 1: LSB first; 2: WIDTH=4 DIV=2.
    int wd_of  [3] = '{8, 8, 4};
    int dv_of  [3] = '{4, 4, 2};
    int msb_of [3] = '{1, 0, 1};

    serial_bit_driver #(.WIDTH(8), .DIV(4), .MSB_FIRST(1'b1)) dut0 (
        .CLK(CLK), .RST(RST), .START(start[0]), .DIN(din0),
        .D(d_o[0]), .E(e_o[0]), .BUSY(busy_o[0]), .DONE(done_o[0]));
    serial_bit_driver #(.WIDTH(8), .DIV(4), .MSB_FIRST(1'b0)) dut1 (
        .CLK(CLK), .RST(RST), .START(start[1]), .DIN(din1),
        .D(d_o[1]), .E(e_o[1]), .BUSY(busy_o[1]), .DONE(done_o[1]));
    serial_bit_driver #(.WIDTH(4), .DIV(2), .MSB_FIRST(1'b1)) dut2 (
        .CLK(CLK), .RST(RST), .START(start[2]), .DIN(din2),
        .D(d_o[2]), .E(e_o[2]), .BUSY(busy_o[2]), .DONE(done_o[2]));

    initial CLK = 1'b0;
    always #8 CLK = ~CLK;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] get_din(input int i);
        case (i)
            0:       return {24'd0, din0};
            1:       return {24'd0, din1};
            default: return {28'd0, din2};
        endcase
    endfunction

    task automatic set_din(input int i, input logic [31:0] w);
        case (i)
            0:       din0 = w[7:0];
            1:       din1 = w[7:0];
            default: din2 = w[3:0];
        endcase
    endtask

    // ---------------- behavioural model ----------------
    // A frame is "edges since accept": during edges 0..W*DIV-1 bit n/DIV is on D,
    // edge W*DIV is the DONE cycle, edge W*DIV+1 returns to idle.
    bit          m_active [3];
    int          m_cnt    [3];
    logic [31:0] m_word   [3];

    always @(posedge CLK or negedge RST) begin
        for (int i = 0; i < 3; i++) begin
            if (!RST) begin
                m_active[i] = 1'b0;
            end else if (m_active[i]) begin
                m_cnt[i] = m_cnt[i] + 1;
                if (m_cnt[i] == wd_of[i] * dv_of[i] + 1) m_active[i] = 1'b0;
            end else if (start[i]) begin
                m_active[i] = 1'b1;
                m_cnt[i]    = 0;
                m_word[i]   = get_din(i);
            end
        end
    end

    function automatic logic sent_bit(input int i, input int k);
        logic [31:0] w;
        w = m_word[i];
        return (msb_of[i] != 0) ? w[wd_of[i] - 1 - k] : w[k];
    endfunction

    // {D, E, BUSY, DONE}
    function automatic logic [3:0] expect_out(input int i);
        int total;
        int n;
        total = wd_of[i] * dv_of[i];
        n     = m_cnt[i];
        if (!m_active[i]) return 4'b1000;
        if (n < total) return {sent_bit(i, n / dv_of[i]), (n % dv_of[i]) == dv_of[i] - 1, 1'b1, 1'b0};
        return 4'b1001;
    endfunction

    // Downstream flop model: whatever sits on D while E is high is captured at the next edge.
    logic [31:0] cap_bits [3];
    int          cap_n    [3];

    always @(negedge CLK) begin
        for (int i = 0; i < 3; i++) begin
            logic [31:0] seq;
            logic [31:0] mask;
            check($sformatf("model inst%0d DEBD", i),
                  {28'd0, d_o[i], e_o[i], busy_o[i], done_o[i]}, {28'd0, expect_out(i)});
            if (!RST) begin
                cap_bits[i] = '0;
                cap_n[i]    = 0;
            end else begin
                if (e_o[i]) begin
                    cap_bits[i] = (cap_bits[i] << 1) | {31'd0, d_o[i]};
                    cap_n[i]    = cap_n[i] + 1;
                end
                if (done_o[i]) begin
                    seq  = '0;
                    mask = (32'd1 << wd_of[i]) - 32'd1;
                    for (int k = 0; k < wd_of[i]; k++) seq[wd_of[i] - 1 - k] = sent_bit(i, k);
                    check($sformatf("flop E count inst%0d", i), cap_n[i], wd_of[i]);
                    check($sformatf("flop bits inst%0d", i), cap_bits[i] & mask, seq);
                    cap_bits[i] = '0;
                    cap_n[i]    = 0;
                end
            end
        end
    end

    // ---------------- literal-pinned single frame ----------------
    // seq holds the hand-written bit order on the wire, first bit at seq[wd-1].
    task automatic frame_lit(input int i, input logic [31:0] w, input int wd, input int dv,
                             input logic [31:0] seq);
        int epulses;
        int done_at;
        epulses = 0;
        done_at = -1;
        @(negedge CLK);
        start[i] = 1'b1;
        set_din(i, w);
        @(negedge CLK);
        start[i] = 1'b0;
        set_din(i, $urandom);
        for (int n = 0; n <= wd * dv; n++) begin
            if (n < wd * dv) begin
                check($sformatf("lit D i%0d n%0d", i, n), {31'd0, d_o[i]}, {31'd0, seq[wd - 1 - n / dv]});
                check($sformatf("lit BUSY i%0d n%0d", i, n), {31'd0, busy_o[i]}, 32'd1);
            end
            if (e_o[i]) epulses++;
            if (done_o[i] && done_at < 0) done_at = n;
            if (n < wd * dv) @(negedge CLK);
        end
        check($sformatf("lit E pulses i%0d", i), epulses, wd);
        check($sformatf("lit DONE cycle i%0d", i), done_at, wd * dv);
    endtask

    initial begin
        int rise[$];
        logic pb;
        int frames;
        int cyc;
        vectors     = 0;
        miscompares = 0;
        RST   = 1'b1;
        start = '0;
        din0  = '0;
        din1  = '0;
        din2  = '0;

        // Reset before any edge, outputs must settle without a clock.
        #3 RST = 1'b0;
        #1;
        check("reset D", {29'd0, d_o}, 32'h7);
        check("reset E", {29'd0, e_o}, 32'h0);
        check("reset BUSY", {29'd0, busy_o}, 32'h0);
        check("reset DONE", {29'd0, done_o}, 32'h0);
        repeat (2) @(negedge CLK);
        check("reset hold D", {29'd0, d_o}, 32'h7);
        check("reset hold BUSY/E", {26'd0, busy_o, e_o}, 32'h0);
        RST = 1'b1;

        // A5, MSB first.
        frame_lit(0, 32'hA5, 8, 4, 32'b10100101);

        // START held, DIN churning: accepts must be 34 clocks apart.
        pb = busy_o[0];
        start[0] = 1'b1;
        for (int c = 0; c < 110; c++) begin
            @(negedge CLK);
            din0 = 8'($urandom);
            if (busy_o[0] && !pb) rise.push_back(c);
            pb = busy_o[0];
        end
        start[0] = 1'b0;
        check("held START frame count", (rise.size() >= 3) ? 32'd1 : 32'd0, 32'd1);
        for (int j = 1; j < rise.size() && j < 3; j++)
            check($sformatf("frame period %0d", j), rise[j] - rise[j-1], 34);
        repeat (40) @(negedge CLK);

        // Abort an FF frame during bit 3.
        @(negedge CLK);
        start[0] = 1'b1;
        din0     = 8'hFF;
        @(negedge CLK);
        start[0] = 1'b0;
        repeat (13) @(negedge CLK);
        @(posedge CLK);
        #3 RST = 1'b0;
        #1;
        check("abort D/E/BUSY/DONE", {28'd0, d_o[0], e_o[0], busy_o[0], done_o[0]}, 32'b1000);
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        frame_lit(0, 32'h3C, 8, 4, 32'b00111100);

        // LSB first: 01 puts the single 1 on the wire first.
        frame_lit(1, 32'h01, 8, 4, 32'b10000000);

        // Short configuration.
        frame_lit(2, 32'h9, 4, 2, 32'b1001);

        // Random START/DIN on all instances until 50 short frames complete.
        frames = 0;
        cyc    = 0;
        while (frames < 50 && cyc < 4000) begin
            @(negedge CLK);
            if (done_o[2]) frames++;
            for (int i = 0; i < 3; i++) begin
                start[i] = ($urandom_range(0, 2) == 0);
                set_din(i, $urandom);
            end
            cyc++;
        end
        check("random frames completed", (frames >= 50) ? 32'd1 : 32'd0, 32'd1);
        start = '0;
        repeat (40) @(negedge CLK);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
